trap_unit: RTL and testbench

Machine-mode trap sequencer sitting directly upstream of the CSR register file. It takes exceptions from the pipeline and external interrupts, then writes mepc, mcause and mtval through the CSR file's second write port, one register per cycle. It pulses trap_begin/trap_end so the CSR file can update mstatus, and issues the PC redirect and flush to the fetch and decode stages. It also sequences mret.

---
 rtl/trap_pkg.sv | 29 ++
 rtl/trap_unit.sv | 146 ++++++++++++++
 tb/tb_trap_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap sequencer: state encoding,
// CSR addresses written through port 2, and fixed cause/vector values.
package trap_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_MEPC   = 3'd1;
    localparam logic [2:0] S_WR_MCAUSE = 3'd2;
    localparam logic [2:0] S_WR_MTVAL  = 3'd3;
    localparam logic [2:0] S_REDIRECT  = 3'd4;
    localparam logic [2:0] S_MRET      = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        WR_MEPC   = S_WR_MEPC,
        WR_MCAUSE = S_WR_MCAUSE,
        WR_MTVAL  = S_WR_MTVAL,
        REDIRECT  = S_REDIRECT,
        MRET      = S_MRET
    } state_t;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    localparam logic [31:0] CAUSE_MEXT = 32'h8000_000B;
    localparam logic [31:0] VEC_OFFSET = 32'd44;
    localparam logic [1:0]  WSC_WRITE  = 2'b01;

endpackage

// File: rtl/trap_unit.sv
// Machine-mode trap sequencer: writes mepc/mcause/mtval one per cycle through
// CSR port 2, then redirects fetch; also sequences mret in a single cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for exception, enabled interrupt or mret
// WR_MEPC   | write mepc, pulse trap_begin/flush/exc_ack
// WR_MCAUSE | write mcause
// WR_MTVAL  | write mtval
// REDIRECT  | redirect fetch to the trap vector
// MRET      | restore MIE, redirect to mepc, flush, exc_ack
module trap_unit
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        ext_int,
    input  logic        mret,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        exc_ack,
    output logic        csr_w2,
    output logic [11:0] waddr2,
    output logic [31:0] wdata2,
    output logic [1:0]  csr_wsc_mode2,
    output logic        trap_begin,
    output logic        trap_end,
    output logic        stall_req,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    state_t      state, state_n;
    logic [31:0] lat_pc, lat_cause, lat_tval;
    logic        lat_int;
    logic        take_exc, take_int;
    logic [31:0] vec_base;

    // Only MIE gates interrupts; the rest of mstatus belongs to the CSR file.
    logic unused_mstatus;
    assign unused_mstatus = ^{mstatus[31:4], mstatus[2:0]};

    assign take_exc = exc_valid;
    assign take_int = ext_int && mstatus[3];
    assign vec_base = {mtvec[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_pc    <= '0;
            lat_cause <= '0;
            lat_tval  <= '0;
            lat_int   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                if (take_exc) begin
                    lat_pc    <= exc_pc;
                    lat_cause <= {28'b0, exc_cause};
                    lat_tval  <= exc_tval;
                    lat_int   <= 1'b0;
                end else if (take_int) begin
                    lat_pc    <= exc_pc;
                    lat_cause <= CAUSE_MEXT;
                    lat_tval  <= '0;
                    lat_int   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (take_exc || take_int) state_n = WR_MEPC;
                else if (mret)            state_n = MRET;
            end
            WR_MEPC:   state_n = WR_MCAUSE;
            WR_MCAUSE: state_n = WR_MTVAL;
            WR_MTVAL:  state_n = REDIRECT;
            REDIRECT:  state_n = IDLE;
            MRET:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        exc_ack       = 1'b0;
        csr_w2        = 1'b0;
        waddr2        = '0;
        wdata2        = '0;
        csr_wsc_mode2 = WSC_WRITE;
        trap_begin    = 1'b0;
        trap_end      = 1'b0;
        stall_req     = 1'b0;
        flush         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        case (state)
            WR_MEPC: begin
                csr_w2     = 1'b1;
                waddr2     = CSR_MEPC;
                wdata2     = lat_pc;
                trap_begin = 1'b1;
                flush      = 1'b1;
                exc_ack    = 1'b1;
                stall_req  = 1'b1;
            end
            WR_MCAUSE: begin
                csr_w2    = 1'b1;
                waddr2    = CSR_MCAUSE;
                wdata2    = lat_cause;
                stall_req = 1'b1;
            end
            WR_MTVAL: begin
                csr_w2    = 1'b1;
                waddr2    = CSR_MTVAL;
                wdata2    = lat_tval;
                stall_req = 1'b1;
            end
            REDIRECT: begin
                redirect  = 1'b1;
                stall_req = 1'b1;
                // Vectored offset applies to interrupts only; modes 2/3 act as direct.
                redirect_pc = (lat_int && mtvec[1:0] == 2'b01) ? vec_base + VEC_OFFSET
                                                                : vec_base;
            end
            MRET: begin
                trap_end    = 1'b1;
                redirect    = 1'b1;
                redirect_pc = mepc;
                flush       = 1'b1;
                exc_ack     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios plus randomized
// events compared against a cycle-level behavioural model of the sequencer.
module tb_trap_unit;

    typedef logic [84:0] vec_t;

    logic        clk, rst;
    logic        exc_valid, ext_int, mret;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval, mstatus, mtvec, mepc;
    logic        exc_ack, csr_w2, trap_begin, trap_end, stall_req, flush, redirect;
    logic [11:0] waddr2;
    logic [31:0] wdata2, redirect_pc;
    logic [1:0]  csr_wsc_mode2;
    vec_t        obs, exp_v;

    int checks = 0;
    int errors = 0;

    trap_unit dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .ext_int(ext_int), .mret(mret),
        .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
        .exc_ack(exc_ack), .csr_w2(csr_w2), .waddr2(waddr2), .wdata2(wdata2),
        .csr_wsc_mode2(csr_wsc_mode2), .trap_begin(trap_begin), .trap_end(trap_end),
        .stall_req(stall_req), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    assign obs = {exc_ack, csr_w2, waddr2, wdata2, csr_wsc_mode2,
                  trap_begin, trap_end, stall_req, flush, redirect, redirect_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired: bench did not finish");
        $fatal(1);
    end

    // Expected outputs for one cycle. phase 0 idle, 1..4 the four trap cycles
    // (mepc, mcause, mtval, redirect), 5 the mret cycle.
    function automatic vec_t model(input int phase, input bit is_int,
                                   input logic [31:0] pc, input logic [31:0] cause,
                                   input logic [31:0] tval, input logic [31:0] tvec,
                                   input logic [31:0] epc);
        logic [31:0] target;
        target = (tvec & 32'hFFFF_FFFC) + ((is_int && (tvec % 4) == 1) ? 32'd44 : 32'd0);
        case (phase)
            1: model = {1'b1, 1'b1, 12'h341, pc,    2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0};
            2: model = {1'b0, 1'b1, 12'h342, cause, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
            3: model = {1'b0, 1'b1, 12'h343, tval,  2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
            4: model = {1'b0, 1'b0, 12'h000, 32'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, target};
            5: model = {1'b1, 1'b0, 12'h000, 32'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, epc};
            default: model = {1'b0, 1'b0, 12'h000, 32'd0, 2'b01, 5'b0, 32'd0};
        endcase
    endfunction

    // Which event an idle unit accepts: 0 none, 1 exception, 2 interrupt, 3 mret.
    function automatic int decide(input bit ev, input bit ei, input bit mie, input bit mr);
        if (ev)             decide = 1;
        else if (ei && mie) decide = 2;
        else if (mr)        decide = 3;
        else                decide = 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
        ext_int = 0; mret = 0; mstatus = 0; mtvec = 0; mepc = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step(); step();
        exp_v = model(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", obs, exp_v);
        end
        checks++;
        rst = 0;
        step();
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL idle_after_reset got %h want %h", obs, exp_v);
        end
        checks++;
    endtask

    task automatic test_illegal();
        exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEADBEEF;
        mtvec = 32'h200; mstatus = 32'h88;
        for (int p = 1; p <= 4; p++) begin
            step();
            exp_v = model(p, 0, 32'h100, 32'd2, 32'hDEADBEEF, mtvec, mepc);
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL illegal_phase%0d got %h want %h", p, obs, exp_v);
            end
            checks++;
            if (p == 1) exc_valid = 0;
        end
        if (redirect_pc !== 32'h200) begin
            errors++;
            $display("FAIL illegal_target got %h want %h", redirect_pc, 32'h200);
        end
        checks++;
        step();
        exp_v = model(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL illegal_back_idle got %h want %h", obs, exp_v);
        end
        checks++;
    endtask

    task automatic test_int_vectored();
        clear_inputs();
        ext_int = 1; mstatus = 32'h88; mtvec = 32'h201; exc_pc = 32'h300;
        exc_tval = 32'h5555_AAAA;
        for (int p = 1; p <= 4; p++) begin
            step();
            exp_v = model(p, 1, 32'h300, 32'h8000000B, 32'd0, mtvec, mepc);
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL int_vec_phase%0d got %h want %h", p, obs, exp_v);
            end
            checks++;
            if (p == 1) mstatus = 32'h80;   // CSR file has cleared MIE
        end
        if (redirect_pc !== 32'h22C) begin
            errors++;
            $display("FAIL int_vec_target got %h want %h", redirect_pc, 32'h22C);
        end
        checks++;
        for (int c = 0; c < 3; c++) begin
            step();
            exp_v = model(0, 0, 0, 0, 0, 0, 0);
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL int_masked_after_return c%0d got %h want %h", c, obs, exp_v);
            end
            checks++;
        end
        ext_int = 0;
    endtask

    task automatic test_int_masked();
        int bad;
        clear_inputs();
        ext_int = 1; mstatus = 32'h80; mtvec = 32'h201;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (csr_w2 || stall_req || redirect) bad++;
        end
        if (bad !== 0) begin
            errors++;
            $display("FAIL int_masked active_cycles got %0d want 0", bad);
        end
        checks++;
        ext_int = 0;
    endtask

    task automatic test_mret();
        clear_inputs();
        mret = 1; mepc = 32'h104; mstatus = 32'h80;
        step();
        mret = 0;
        exp_v = model(5, 0, 0, 0, 0, 0, 32'h104);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mret_cycle got %h want %h", obs, exp_v);
        end
        checks++;
        step();
        exp_v = model(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mret_back_idle got %h want %h", obs, exp_v);
        end
        checks++;
    endtask

    task automatic test_priority();
        clear_inputs();
        exc_valid = 1; ext_int = 1; mret = 1; mstatus = 32'h88;
        exc_cause = 4'd5; exc_pc = 32'h400; exc_tval = 32'h11;
        mtvec = 32'h201; mepc = 32'h900;
        for (int p = 1; p <= 4; p++) begin
            step();
            exp_v = model(p, 0, 32'h400, 32'd5, 32'h11, mtvec, mepc);
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL priority_phase%0d got %h want %h", p, obs, exp_v);
            end
            checks++;
            if (p == 1) begin
                exc_valid = 0; mret = 0; ext_int = 0;
            end
        end
        step();
        exp_v = model(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL priority_no_mret got %h want %h", obs, exp_v);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int acks;
        clear_inputs();
        mtvec = 32'h1000;
        exc_valid = 1; exc_cause = 4'd3; exc_pc = 32'hA0; exc_tval = 32'h1;
        acks = 0;
        for (int p = 1; p <= 4; p++) begin
            step();
            acks += exc_ack;
            exp_v = model(p, 0, 32'hA0, 32'd3, 32'h1, mtvec, mepc);
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL busy_first_phase%0d got %h want %h", p, obs, exp_v);
            end
            checks++;
            if (p == 1) exc_valid = 0;
            if (p == 2) begin
                exc_valid = 1; exc_cause = 4'd7; exc_pc = 32'hB0; exc_tval = 32'h2;
            end
        end
        step();
        acks += exc_ack;
        exp_v = model(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL busy_idle_gap got %h want %h", obs, exp_v);
        end
        checks++;
        for (int p = 1; p <= 4; p++) begin
            step();
            acks += exc_ack;
            exp_v = model(p, 0, 32'hB0, 32'd7, 32'h2, mtvec, mepc);
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL busy_second_phase%0d got %h want %h", p, obs, exp_v);
            end
            checks++;
            if (p == 1) exc_valid = 0;
        end
        step();
        acks += exc_ack;
        if (acks !== 2) begin
            errors++;
            $display("FAIL busy_ack_count got %0d want 2", acks);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int redirs;
        clear_inputs();
        mtvec = 32'h200;
        exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h180; exc_tval = 32'h3;
        step();
        exc_valid = 0;
        step();
        exp_v = model(2, 0, 32'h180, 32'd2, 32'h3, mtvec, mepc);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rstmid_mcause got %h want %h", obs, exp_v);
        end
        checks++;
        rst = 1;
        step();
        rst = 0;
        exp_v = model(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rstmid_outputs got %h want %h", obs, exp_v);
        end
        checks++;
        redirs = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            redirs += redirect;
        end
        if (redirs !== 0) begin
            errors++;
            $display("FAIL rstmid_redirects got %0d want 0", redirs);
        end
        checks++;
    endtask

    task automatic test_random();
        int          kind;
        bit          is_int;
        logic [31:0] l_pc, l_cause, l_tval;
        for (int it = 0; it < 300; it++) begin
            exc_valid = ($urandom_range(0, 3) == 0);
            ext_int   = ($urandom_range(0, 2) == 0);
            mret      = ($urandom_range(0, 2) == 0);
            mstatus   = $urandom;
            mtvec     = $urandom;
            mepc      = $urandom;
            exc_cause = 4'($urandom);
            exc_pc    = $urandom;
            exc_tval  = $urandom;
            kind = decide(exc_valid, ext_int, mstatus[3], mret);
            is_int  = (kind == 2);
            l_pc    = exc_pc;
            l_cause = is_int ? 32'h8000000B : {28'd0, exc_cause};
            l_tval  = is_int ? 32'd0 : exc_tval;
            step();
            if (kind == 1 || kind == 2) begin
                for (int p = 1; p <= 4; p++) begin
                    if (p > 1) step();
                    exp_v = model(p, is_int, l_pc, l_cause, l_tval, mtvec, mepc);
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL rand_it%0d_phase%0d got %h want %h", it, p, obs, exp_v);
                    end
                    checks++;
                    exc_valid = $urandom_range(0, 1);
                    ext_int   = $urandom_range(0, 1);
                    mret      = $urandom_range(0, 1);
                    mstatus   = $urandom;
                    mtvec     = $urandom;
                    mepc      = $urandom;
                end
                step();
            end else if (kind == 3) begin
                exp_v = model(5, 0, 0, 0, 0, mtvec, mepc);
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL rand_it%0d_mret got %h want %h", it, obs, exp_v);
                end
                checks++;
                exc_valid = $urandom_range(0, 1);
                ext_int   = $urandom_range(0, 1);
                mret      = $urandom_range(0, 1);
                mstatus   = $urandom;
                step();
            end
            exp_v = model(0, 0, 0, 0, 0, 0, 0);
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rand_it%0d_idle got %h want %h", it, obs, exp_v);
            end
            checks++;
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_illegal();
        test_int_vectored();
        test_int_masked();
        test_mret();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
